// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP compare op encodings and result constants
package fpu_pkg;

  typedef enum logic [1:0] {
    FCMP_EQ = 2'b00,
    FCMP_LT = 2'b01,
    FCMP_LE = 2'b10
  } fcmp_op_t;

  localparam logic [31:0] FP_ONE  = 32'h3f800000;
  localparam logic [31:0] FP_ZERO = 32'h0;

endpackage

// File: rtl/fcmp_arbiter_if.sv
// rtl/fcmp_arbiter_if.sv - requester-side request/response bundle for the shared FP compare unit
interface fcmp_arbiter_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_x1;
  logic [32*NREQ-1:0]   req_x2;
  logic [NREQ-1:0]      rsp_valid;
  logic [32*NREQ-1:0]   rsp_data;
  logic [NREQ-1:0]      rsp_ready;

  // requester side
  modport master (
    output req_valid, req_op, req_x1, req_x2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // arbiter side
  modport slave (
    input  req_valid, req_op, req_x1, req_x2, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TAGW-1:0] ptr,
  output logic            gnt_valid,
  output logic [TAGW-1:0] gnt_idx,
  output logic [NREQ-1:0] gnt,
  output logic [TAGW-1:0] ptr_next
);

  // scan upward from ptr with wrap; first requester found wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_valid && req[(int'(ptr) + k) % NREQ]) begin
        gnt_valid = 1'b1;
        gnt_idx   = TAGW'((int'(ptr) + k) % NREQ);
      end
    end
    gnt = '0;
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
    ptr_next = ptr;
    if (gnt_valid) begin
      ptr_next = (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);
    end
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// rtl/fcmp_arbiter.sv - round-robin sharing of one pipelined FP compare unit; FCMP_ARB_PERF_EN adds perf counters
module fcmp_arbiter
  import fpu_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int LAT  = 1,
  localparam int TAGW = $clog2(NREQ)
) (
  input  logic                sys_clk,
  input  logic                rst,
  fcmp_arbiter_if.slave       req_if,
  output logic                cu_in_valid,
  output logic [1:0]          cu_op,
  output logic [31:0]         cu_x1,
  output logic [31:0]         cu_x2,
  input  logic                cu_out_valid,
  input  logic [31:0]         cu_y,
  output logic                err_orphan
`ifdef FCMP_ARB_PERF_EN
  ,
  output logic [31:0]         perf_issue_cnt,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_block_cnt
`endif
);

  logic [TAGW-1:0]           rr_q, rr_d;
  logic [NREQ-1:0]           busy_q, busy_d;
  logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [32*NREQ-1:0]        rsp_data_q, rsp_data_d;
  logic                      cu_in_valid_q, cu_in_valid_d;
  logic [1:0]                cu_op_q, cu_op_d;
  logic [31:0]               cu_x1_q, cu_x1_d;
  logic [31:0]               cu_x2_q, cu_x2_d;
  logic [TAGW-1:0]           iss_tag_q, iss_tag_d;
  logic [LAT-1:0]            pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0][TAGW-1:0]  pipe_tag_q, pipe_tag_d;
  logic                      err_orphan_q, err_orphan_d;

  logic [NREQ-1:0]           elig;
  logic                      gnt_valid;
  logic [TAGW-1:0]           gnt_idx;
  logic [NREQ-1:0]           gnt;
  logic [TAGW-1:0]           ptr_next;
  logic                      gnt_ok;
  logic                      head_vld;
  logic [TAGW-1:0]           head_tag;

  assign elig = req_if.req_valid & ~busy_q;

  rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_rr (
    .req       (elig),
    .ptr       (rr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .ptr_next  (ptr_next)
  );

  // a grant during reset would be discarded, so it is never advertised
  assign gnt_ok   = gnt_valid & ~rst;
  assign head_vld = pipe_vld_q[LAT-1];
  assign head_tag = pipe_tag_q[LAT-1];

  assign req_if.req_ready = gnt & {NREQ{~rst}};
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign cu_in_valid      = cu_in_valid_q;
  assign cu_op            = cu_op_q;
  assign cu_x1            = cu_x1_q;
  assign cu_x2            = cu_x2_q;
  assign err_orphan       = err_orphan_q;

  // issue, tag tracking, result capture and response handshake
  always_comb begin
    rr_d          = rr_q;
    busy_d        = busy_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    cu_in_valid_d = 1'b0;
    cu_op_d       = cu_op_q;
    cu_x1_d       = cu_x1_q;
    cu_x2_d       = cu_x2_q;
    iss_tag_d     = iss_tag_q;
    pipe_vld_d    = pipe_vld_q;
    pipe_tag_d    = pipe_tag_q;
    err_orphan_d  = err_orphan_q;

    if (gnt_ok) begin
      cu_in_valid_d   = 1'b1;
      cu_op_d         = req_if.req_op[2*gnt_idx +: 2];
      cu_x1_d         = req_if.req_x1[32*gnt_idx +: 32];
      cu_x2_d         = req_if.req_x2[32*gnt_idx +: 32];
      iss_tag_d       = gnt_idx;
      busy_d[gnt_idx] = 1'b1;
      rr_d            = ptr_next;
    end

    // the issue register is the stage ahead of the pipe, so the head lines up with cu_out_valid
    pipe_vld_d[0] = cu_in_valid_q;
    pipe_tag_d[0] = iss_tag_q;
    for (int k = 1; k < LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_tag_d[k] = pipe_tag_q[k-1];
    end

    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid_q[i] && req_if.rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
        busy_d[i]      = 1'b0;
      end
    end

    // a missing result leaves busy set, locking that requester until reset
    if (cu_out_valid && head_vld) begin
      rsp_valid_d[head_tag]           = 1'b1;
      rsp_data_d[32*head_tag +: 32]   = cu_y;
    end
    if (cu_out_valid != head_vld) begin
      err_orphan_d = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rr_q          <= '0;
      busy_q        <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      cu_in_valid_q <= 1'b0;
      cu_op_q       <= '0;
      cu_x1_q       <= '0;
      cu_x2_q       <= '0;
      iss_tag_q     <= '0;
      pipe_vld_q    <= '0;
      pipe_tag_q    <= '0;
      err_orphan_q  <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      cu_in_valid_q <= cu_in_valid_d;
      cu_op_q       <= cu_op_d;
      cu_x1_q       <= cu_x1_d;
      cu_x2_q       <= cu_x2_d;
      iss_tag_q     <= iss_tag_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_tag_q    <= pipe_tag_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

`ifdef FCMP_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_block_q, perf_block_d;

  // grant, contention and all-blocked cycle counters, wrapping naturally
  always_comb begin
    perf_issue_d    = perf_issue_q + {31'd0, gnt_ok};
    perf_conflict_d = perf_conflict_q;
    perf_block_d    = perf_block_q;
    if ($countones(elig) >= 2) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
    if ((|req_if.req_valid) && !(|elig)) begin
      perf_block_d = perf_block_q + 32'd1;
    end
  end

  // perf counter registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      perf_issue_q    <= '0;
      perf_conflict_q <= '0;
      perf_block_q    <= '0;
    end else begin
      perf_issue_q    <= perf_issue_d;
      perf_conflict_q <= perf_conflict_d;
      perf_block_q    <= perf_block_d;
    end
  end

  assign perf_issue_cnt    = perf_issue_q;
  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_block_cnt    = perf_block_q;
`endif

endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
- Shares one pipelined FP compare unit (feq/flt/fle; result is 1.0f or 0.0f) between NREQ requesters.
- Arbitrates round-robin and issues registered operands to the unit.
- Tracks the owner of each in-flight op with a tag pipe matched to the unit latency.
- Holds each result in a per-requester response buffer until the requester accepts it.
- Sits between the core's FP issue ports and the shared compare unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 1, fixed compare-unit latency in cycles, from cu_in_valid sampled to cu_out_valid (≥1).
- TAGW, $clog2(NREQ), owner tag width (derived; do not override).

Ports:
- sys_clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  request accepted this cycle.
- req_op  in  2*NREQ  op per requester: 00 feq, 01 flt, 10 fle, 11 reserved (forwarded untouched).
- req_x1  in  32*NREQ  operand 1 per requester.
- req_x2  in  32*NREQ  operand 2 per requester.
- rsp_valid  out  NREQ  result available.
- rsp_data  out  32*NREQ  result per requester.
- rsp_ready  in  NREQ  requester takes the result.
- cu_in_valid  out  1  issue to the compare unit.
- cu_op  out  2  op to the unit.
- cu_x1  out  32  operand 1 to the unit.
- cu_x2  out  32  operand 2 to the unit.
- cu_out_valid  in  1  unit result valid.
- cu_y  in  32  unit result.
- err_orphan  out  1  sticky: result arrived with no matching tag.

Behaviour:
- Reset state (rst high at a posedge): all outputs 0, all busy flags 0, all response buffers empty, tag pipe cleared, rr pointer 0.
- The compare unit shares rst. Any result it emits after reset with an empty tag-pipe head sets err_orphan.
- Eligibility: requester i is eligible when req_valid[i]=1 and busy[i]=0. At most one op is outstanding per requester.
- Arbitration:
  - Scan from rr pointer upward, wrapping at NREQ. The first eligible requester g is granted.
  - req_ready[g]=1 combinationally in the grant cycle; all other req_ready bits are 0.
  - The pointer moves to (g+1) mod NREQ only on a grant; otherwise it holds.
- Issue: on a grant, at the posedge:
  - cu_in_valid<=1; cu_op/x1/x2 <= requester g's fields.
  - busy[g]<=1.
  - The tag pipe shifts in {1,g}.
  - With no grant, cu_in_valid<=0, operand registers hold their values, and {0,x} is shifted in.
- Tag pipe: a LAT-stage shift register aligned so its head is valid exactly when cu_out_valid is expected.
- Result capture: when cu_out_valid=1 and the head is valid with tag t:
  - rsp_data[t]<=cu_y and rsp_valid[t]<=1.
  - A result with an invalid head sets err_orphan (sticky until rst); the result is dropped.
  - If the head is valid but cu_out_valid=0, busy[t] stays set, err_orphan is set, and that requester is locked until reset (unit fault).
- Response handshake:
  - rsp_valid[i] holds until rsp_valid[i]&&rsp_ready[i] at a posedge. That edge clears rsp_valid[i] and busy[i].
  - Requester i becomes eligible again the following cycle; there is no same-cycle bypass.
- Simultaneous events:
  - A grant to i and a response handshake for i in the same cycle cannot occur, because busy[i] blocks the grant.
  - Capture for one requester and a handshake for another proceed independently.
- Throughput: one issue per cycle across requesters. A single requester's round trip is ≥ LAT+3 cycles (issue reg + LAT + capture + handshake).

Optional Feature:
- Macro FCMP_ARB_PERF_EN.
- When defined, add ports:
  - perf_issue_cnt out 32: total grants.
  - perf_conflict_cnt out 32: cycles with ≥2 eligible requesters.
  - perf_block_cnt out 32: cycles where some req_valid=1 but no requester is eligible.
- All counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fpu_pkg:
  - enum fcmp_op_t (FCMP_EQ=2'b00, FCMP_LT=2'b01, FCMP_LE=2'b10).
  - localparams FP_ONE=32'h3f800000 and FP_ZERO=32'h0.
- One sub-module: rr_arbiter (NREQ-wide request vector plus pointer → one-hot grant and next pointer), purely combinational.
- The tag pipe and response buffers stay inline.

Test Plan:
- Single request: requester 0 sends fle, x1=3f800000, x2=40000000, LAT=1. req_ready[0] is high in cycle 0, cu_in_valid in cycle 1, rsp_valid[0] high with rsp_data[0]=3f800000 in cycle 3, and held until rsp_ready[0].
- All 4 requesters assert every cycle with immediate rsp_ready: grants go 0,1,2,3,0,…, one per cycle with no starvation. Each requester's results return in issue order with correct 1.0/0.0 values.
- Backpressure: hold rsp_ready[2]=0 for 10 cycles. Requester 2 gets no second grant, rsp_data[2] is stable, and the others continue at full rate.
- Assert rst while 3 ops are in flight: the next cycle all rsp_valid=0, req_ready=0, cu_in_valid=0, and the pointer is 0. The first post-reset grant goes to the lowest eligible requester.
- Inject cu_out_valid=1 with no issue: err_orphan=1 and stays 1 until rst; no rsp_valid is raised.
- With FCMP_ARB_PERF_EN, 4 requesters contend for 8 cycles: perf_issue_cnt=8 and perf_conflict_cnt≥1, both matching a scoreboard model.
